// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with same-cycle write-back bypass and a
// per-register pending (scoreboard) bit. An issued destination stays pending
// until its write-back arrives. Register 0 is hardwired to zero and is never
// pending.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] write_back,
   input  logic [ADDR_W-1:0] rdAddr1,
   input  logic [ADDR_W-1:0] rdAddr2,
   output logic [DATA_W-1:0] dataOut1,
   output logic [DATA_W-1:0] dataOut2,
   input  logic              issueValid,
   input  logic [ADDR_W-1:0] issueAddr,
   output logic              busy1,
   output logic              busy2,
   output logic              hazard,
   output logic [ADDR_W:0]   pendCount
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_reg [NREGS];
   logic [NREGS-1:0]  pending_reg;
   logic [NREGS-1:0]  pending_next;
   logic [ADDR_W:0]   pend_count_reg;
   logic [ADDR_W:0]   pend_count_next;

   // Writes and issues to register 0 are dropped. Both are also gated off
   // while reset is held, so the bypass cannot leak data onto the read ports.
   logic wr_en;
   logic iss_en;
   assign wr_en  = regWrite   && !reset && (wrAddr    != '0);
   assign iss_en = issueValid && !reset && (issueAddr != '0);

   // Register storage; entry 0 is cleared by reset and never written again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wr_en) begin
         regs_reg[wrAddr] <= write_back;
      end
   end

   // Next pending vector. The write-back clears the bit first and the issue
   // then sets it, so an issue wins when both target the same register.
   always_comb begin
      pending_next = pending_reg;
      if (wr_en) begin
         pending_next[wrAddr] = 1'b0;
      end
      if (iss_en) begin
         pending_next[issueAddr] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   // Population count of the next pending vector, so the registered count
   // tracks the pending bits on the same edge.
   always_comb begin
      pend_count_next = '0;
      for (int i = 0; i < NREGS; i++) begin
         pend_count_next = pend_count_next + {{ADDR_W{1'b0}}, pending_next[i]};
      end
   end

   // Pending vector and its registered count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg    <= '0;
         pend_count_reg <= '0;
      end else begin
         pending_reg    <= pending_next;
         pend_count_reg <= pend_count_next;
      end
   end

   // Both read ports share one implementation, indexed by port number.
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   assign rd_addr[0] = rdAddr1;
   assign rd_addr[1] = rdAddr2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic wr_hit;
         // wr_en already excludes register 0, so no bypass is possible there.
         assign wr_hit = wr_en && (wrAddr == rd_addr[gi]);
         // Same-cycle write-back data is forwarded ahead of the stored value.
         assign rd_data[gi] = wr_hit ? write_back : regs_reg[rd_addr[gi]];
         // A write-back arriving this cycle releases the hazard immediately.
         assign rd_busy[gi] = pending_reg[rd_addr[gi]] &&
                              !(regWrite && (wrAddr == rd_addr[gi]));
      end
   endgenerate

   assign dataOut1  = rd_data[0];
   assign dataOut2  = rd_data[1];
   assign busy1     = rd_busy[0];
   assign busy2     = rd_busy[1];
   assign hazard    = rd_busy[0] | rd_busy[1];
   assign pendCount = pend_count_reg;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb. Expected values are queued
// as each stimulus step is driven and popped when the output is sampled.
module tb_reg_file_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              reset;
   logic              regWrite;
   logic [ADDR_W-1:0] wrAddr;
   logic [DATA_W-1:0] write_back;
   logic [ADDR_W-1:0] rdAddr1;
   logic [ADDR_W-1:0] rdAddr2;
   logic [DATA_W-1:0] dataOut1;
   logic [DATA_W-1:0] dataOut2;
   logic              issueValid;
   logic [ADDR_W-1:0] issueAddr;
   logic              busy1;
   logic              busy2;
   logic              hazard;
   logic [ADDR_W:0]   pendCount;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q [$];
   logic [31:0] model_pend;

   reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .regWrite   (regWrite),
      .wrAddr     (wrAddr),
      .write_back (write_back),
      .rdAddr1    (rdAddr1),
      .rdAddr2    (rdAddr2),
      .dataOut1   (dataOut1),
      .dataOut2   (dataOut2),
      .issueValid (issueValid),
      .issueAddr  (issueAddr),
      .busy1      (busy1),
      .busy2      (busy2),
      .hazard     (hazard),
      .pendCount  (pendCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         $display("check %s observed=%h expected=%h", tag, obs, e);
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic idle();
      regWrite   = 1'b0;
      wrAddr     = '0;
      write_back = '0;
      issueValid = 1'b0;
      issueAddr  = '0;
   endtask

   initial begin
      idle();
      rdAddr1    = '0;
      rdAddr2    = '0;
      reset      = 1'b0;
      model_pend = '0;

      // Reset
      #1 reset = 1'b1;
      #1;
      push_exp(32'h0); check("rst_pend",   32'(pendCount));
      push_exp(32'h0); check("rst_hazard", 32'(hazard));
      push_exp(32'h0); check("rst_data1",  dataOut1);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Write reg 8, read it back next cycle
      @(negedge clk);
      regWrite = 1'b1; wrAddr = 5'd8; write_back = 32'hDEADBEEF; rdAddr1 = 5'd0;
      @(negedge clk);
      idle(); rdAddr1 = 5'd8;
      #1 push_exp(32'hDEADBEEF); check("rd_reg8", dataOut1);

      // Write to reg 0 is ignored, including the bypass
      @(negedge clk);
      regWrite = 1'b1; wrAddr = 5'd0; write_back = 32'hFFFFFFFF; rdAddr2 = 5'd0;
      #1 push_exp(32'h0); check("reg0_bypass", dataOut2);
      @(negedge clk);
      idle(); rdAddr1 = 5'd0;
      #1 push_exp(32'h0); check("reg0_read", dataOut1);

      // Bypass on port 2 while port 1 reads stored data
      @(negedge clk);
      regWrite = 1'b1; wrAddr = 5'd9; write_back = 32'h12345678;
      rdAddr1 = 5'd8; rdAddr2 = 5'd9;
      #1 push_exp(32'h12345678); check("bypass2", dataOut2);
      push_exp(32'hDEADBEEF); check("port1_plain", dataOut1);
      @(negedge clk);
      idle(); rdAddr1 = 5'd9; rdAddr2 = 5'd9;
      #1 push_exp(32'h12345678); check("same_reg_p1", dataOut1);
      push_exp(32'h12345678); check("same_reg_p2", dataOut2);

      // Issue reg 10, observe hazard, release with write-back
      @(negedge clk);
      issueValid = 1'b1; issueAddr = 5'd10;
      @(negedge clk);
      idle(); rdAddr1 = 5'd10; rdAddr2 = 5'd9;
      #1 push_exp(32'h1); check("busy1_set", 32'(busy1));
      push_exp(32'h0); check("busy2_clear", 32'(busy2));
      push_exp(32'h1); check("hazard_set", 32'(hazard));
      push_exp(32'h1); check("pend_1", 32'(pendCount));
      @(negedge clk);
      regWrite = 1'b1; wrAddr = 5'd10; write_back = 32'hAAAA5555;
      #1 push_exp(32'h0); check("busy1_release", 32'(busy1));
      push_exp(32'h0); check("hazard_release", 32'(hazard));
      push_exp(32'hAAAA5555); check("wb_bypass10", dataOut1);
      push_exp(32'h1); check("pend_before_edge", 32'(pendCount));
      @(posedge clk);
      #1 push_exp(32'h0); check("pend_after_wb", 32'(pendCount));

      // Simultaneous issue and write-back on an already-pending reg 11
      @(negedge clk);
      idle(); issueValid = 1'b1; issueAddr = 5'd11;
      @(negedge clk);
      idle(); rdAddr1 = 5'd11;
      #1 push_exp(32'h1); check("pend_11", 32'(pendCount));
      @(negedge clk);
      issueValid = 1'b1; issueAddr = 5'd11;
      regWrite = 1'b1; wrAddr = 5'd11; write_back = 32'h0BADF00D;
      #1 push_exp(32'h0BADF00D); check("iss_wb_bypass", dataOut1);
      @(negedge clk);
      idle();
      #1 push_exp(32'h0BADF00D); check("iss_wb_data", dataOut1);
      push_exp(32'h1); check("iss_wb_busy", 32'(busy1));
      push_exp(32'h1); check("iss_wb_pend", 32'(pendCount));

      // Write-back to a non-pending register leaves the count alone
      @(negedge clk);
      regWrite = 1'b1; wrAddr = 5'd12; write_back = 32'h00C0FFEE;
      @(negedge clk);
      idle(); rdAddr2 = 5'd12;
      #1 push_exp(32'h00C0FFEE); check("nonpend_data", dataOut2);
      push_exp(32'h0); check("nonpend_busy", 32'(busy2));
      push_exp(32'h1); check("nonpend_count", 32'(pendCount));

      // Issue regs 1..31 on consecutive cycles, tracked by a bench-side vector
      model_pend[11] = 1'b1;
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         issueValid = 1'b1; issueAddr = 5'(i);
         model_pend[i] = 1'b1;
         @(posedge clk);
         #1 push_exp(32'($countones(model_pend)));
         check($sformatf("fill_%0d", i), 32'(pendCount));
      end

      // Issue to reg 0 and re-issue of a pending reg leave the count at 31
      @(negedge clk);
      issueValid = 1'b1; issueAddr = 5'd0;
      @(posedge clk);
      #1 push_exp(32'd31); check("issue_reg0", 32'(pendCount));
      @(negedge clk);
      issueAddr = 5'd5;
      @(posedge clk);
      #1 push_exp(32'd31); check("reissue_5", 32'(pendCount));

      // Reset asserted between edges with a write and issue in flight
      @(negedge clk);
      issueValid = 1'b1; issueAddr = 5'd5;
      regWrite = 1'b1; wrAddr = 5'd3; write_back = 32'h55AA55AA;
      rdAddr1 = 5'd3; rdAddr2 = 5'd11;
      #2 reset = 1'b1;
      #1 push_exp(32'h0); check("async_pend", 32'(pendCount));
      push_exp(32'h0); check("async_data1", dataOut1);
      push_exp(32'h0); check("async_data2", dataOut2);
      push_exp(32'h0); check("async_busy2", 32'(busy2));
      push_exp(32'h0); check("async_hazard", 32'(hazard));
      @(posedge clk);
      #1 push_exp(32'h0); check("rst_hold_pend", 32'(pendCount));
      @(negedge clk);
      idle(); reset = 1'b0; rdAddr1 = 5'd8;
      #1 push_exp(32'h0); check("post_rst_reg8", dataOut1);

      // Normal operation resumes on the first edge after reset
      @(negedge clk);
      issueValid = 1'b1; issueAddr = 5'd7;
      @(negedge clk);
      idle(); rdAddr2 = 5'd7;
      #1 push_exp(32'h1); check("resume_pend", 32'(pendCount));
      push_exp(32'h1); check("resume_busy2", 32'(busy2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; NREGS = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port regWrite  input  1  write-back enable.
REQ-006 SHALL have port wrAddr  input  ADDR_W  write-back destination index.
REQ-007 SHALL have port write_back  input  DATA_W  write-back data.
REQ-008 SHALL have ports rdAddr1, rdAddr2  input  ADDR_W  read-port source indices.
REQ-009 SHALL have ports dataOut1, dataOut2  output  DATA_W  combinational read data.
REQ-010 SHALL have port issueValid  input  1  marks a destination as awaiting write-back.
REQ-011 SHALL have port issueAddr  input  ADDR_W  destination being issued.
REQ-012 SHALL have ports busy1, busy2  output  1  source operand on port 1/2 is pending.
REQ-013 SHALL have port hazard  output  1  busy1 OR busy2.
REQ-014 SHALL have port pendCount  output  ADDR_W+1  number of pending registers.

Function
REQ-015 SHALL hold NREGS x DATA_W storage plus an NREGS-bit pending vector.
REQ-016 SHALL hardwire register 0: reads return 0, writes ignored, issue ignored, never pending.
REQ-017 SHALL write write_back into register wrAddr at the rising edge when regWrite=1 and wrAddr!=0.
REQ-018 SHALL drive dataOutN = storage[rdAddrN] combinationally, zero-latency.
REQ-019 SHALL bypass: when regWrite=1, wrAddr=rdAddrN and rdAddrN!=0, dataOutN = write_back in the same cycle.
REQ-020 SHALL set pending[issueAddr] at the edge when issueValid=1 and issueAddr!=0.
REQ-021 SHALL clear pending[wrAddr] at the edge when regWrite=1 and wrAddr!=0.
REQ-022 SHALL, on simultaneous issue and write-back to the same register, leave it pending (issue wins; data still written).
REQ-023 SHALL accept write-back to a non-pending register: data written, pending unchanged (stays 0).
REQ-024 SHALL accept issue to an already-pending register: pending stays 1, pendCount unchanged.
REQ-025 SHALL drive busyN = pending[rdAddrN] AND NOT (regWrite AND wrAddr=rdAddrN), i.e. a same-cycle write-back releases the hazard.
REQ-026 SHALL register pendCount as the population count of the next pending vector, updated on the same edge; range 0..NREGS-1, no wrap possible.
REQ-027 SHALL allow both read ports to address the same register with identical results.
REQ-028 SHALL have no other latency: write visible to plain read on the cycle after the edge, via bypass in the write cycle.

Reset
REQ-029 SHALL, while reset=1, asynchronously clear all registers to 0, pending to 0, pendCount to 0; hence dataOut1/2=0, busy1/2=0, hazard=0.
REQ-030 SHALL ignore regWrite and issueValid while reset=1; a write or issue coincident with reset assertion mid-operation is discarded.
REQ-031 SHALL resume normal updates on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL be tested: reset, write 32'hDEADBEEF to reg 8, next cycle read rdAddr1=8 -> dataOut1=32'hDEADBEEF; write to reg 0 then read -> 0.
REQ-033 SHALL be tested: regWrite=1, wrAddr=9, write_back=32'h12345678, rdAddr2=9 in same cycle -> dataOut2=32'h12345678 before the edge.
REQ-034 SHALL be tested: issue reg 10, then rdAddr1=10 -> busy1=1, hazard=1, pendCount=1; write-back reg 10 -> busy1=0 in that cycle, pendCount=0 after edge.
REQ-035 SHALL be tested: issue reg 11 and write-back reg 11 in same cycle (reg previously pending) -> reg 11 holds new data, still pending, pendCount unchanged.
REQ-036 SHALL be tested: issue regs 1..31 on consecutive cycles -> pendCount=31; issue reg 0 -> pendCount stays 31; assert reset mid-sequence -> pendCount=0 and all outputs 0 immediately, without waiting for a clock edge.
